// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block and the jump unit:
// FSM state encoding, PC-select codes and the control-output bundle.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_REDIRECT = 2'b10
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  localparam int         WD_W   = 8;
  localparam logic [7:0] WD_MAX = 8'd255;

  typedef struct packed {
    logic    pc_en;
    logic    if_id_en;
    logic    ex_mem_en;
    logic    if_id_clr;
    logic    id_ex_clr;
    pc_sel_e pc_sel;
  } ctrl_out_t;

  function automatic ctrl_out_t ctrl_run();
    return '{pc_en: 1'b1, if_id_en: 1'b1, ex_mem_en: 1'b1,
             if_id_clr: 1'b0, id_ex_clr: 1'b0, pc_sel: PC_PLUS4};
  endfunction

  function automatic ctrl_out_t ctrl_freeze();
    return '{pc_en: 1'b0, if_id_en: 1'b0, ex_mem_en: 1'b0,
             if_id_clr: 1'b0, id_ex_clr: 1'b0, pc_sel: PC_PLUS4};
  endfunction

  // Load-use: hold PC and IF/ID, bubble into EX, let the load proceed.
  function automatic ctrl_out_t ctrl_stall();
    return '{pc_en: 1'b0, if_id_en: 1'b0, ex_mem_en: 1'b1,
             if_id_clr: 1'b0, id_ex_clr: 1'b1, pc_sel: PC_PLUS4};
  endfunction

  function automatic ctrl_out_t ctrl_flush(input logic [1:0] sel);
    return '{pc_en: 1'b1, if_id_en: 1'b1, ex_mem_en: 1'b1,
             if_id_clr: 1'b1, id_ex_clr: 1'b1, pc_sel: pc_sel_e'(sel)};
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the EX load and ID sources.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait watchdog.
// Define PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_req,
  input  logic [1:0]  jmp_sel,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        ex_mem_en,
  output logic        if_id_clr,
  output logic        id_ex_clr,
  output logic [1:0]  pc_sel,
  output logic        mem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  ctrl_state_e      state;
  logic             pend;
  pc_sel_e          pend_sel;
  logic [WD_W-1:0]  wd_cnt;
  logic             load_use;
  ctrl_out_t        ctrl;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // Priority inside RUN: mem_busy, then flush, then load-use.
  always_comb begin
    // NOTE: default first so every path assigns ctrl and no latch is inferred.
    ctrl = ctrl_run();
    case (state)
      ST_RUN: begin
        if (mem_busy)       ctrl = ctrl_freeze();
        else if (flush_req) ctrl = ctrl_flush(jmp_sel);
        else if (load_use)  ctrl = ctrl_stall();
      end
      ST_MEM_WAIT: ctrl = ctrl_freeze();
      ST_REDIRECT: begin
        if (mem_busy) ctrl = ctrl_freeze();
        else          ctrl = ctrl_flush(pend_sel);
      end
      default: ctrl = ctrl_freeze();
    endcase
  end

  assign pc_en     = ctrl.pc_en;
  assign if_id_en  = ctrl.if_id_en;
  assign ex_mem_en = ctrl.ex_mem_en;
  assign if_id_clr = ctrl.if_id_clr;
  assign id_ex_clr = ctrl.id_ex_clr;
  assign pc_sel    = ctrl.pc_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep all state updates edge-aligned.
    if (!rst_n) begin
      state    <= ST_RUN;
      pend     <= 1'b0;
      pend_sel <= PC_PLUS4;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_busy) begin
            state <= ST_MEM_WAIT;
            if (flush_req) begin
              pend     <= 1'b1;
              pend_sel <= pc_sel_e'(jmp_sel);
            end
          end
        end
        ST_MEM_WAIT: begin
          // Only the first flush seen while frozen is kept.
          if (flush_req && !pend) begin
            pend     <= 1'b1;
            pend_sel <= pc_sel_e'(jmp_sel);
          end
          if (!mem_busy) begin
            state <= (pend || flush_req) ? ST_REDIRECT : ST_RUN;
          end
        end
        ST_REDIRECT: begin
          if (mem_busy) begin
            state <= ST_MEM_WAIT;
          end else begin
            state <= ST_RUN;
            pend  <= 1'b0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Watchdog counts busy MEM_WAIT cycles; the 255th such cycle trips the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (state == ST_MEM_WAIT && mem_busy) begin
        if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 8'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (state == ST_MEM_WAIT && wd_cnt >= WD_MAX - 8'd1) mem_timeout <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // if_id_clr is asserted exactly when a flush is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, ~ctrl.pc_en};
      flush_cnt_q <= flush_cnt_q + {31'd0, ctrl.if_id_clr};
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_req = 1'b0;
  logic [1:0]  jmp_sel = 2'b00;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic [4:0]  id_rs1 = 5'd0;
  logic [4:0]  id_rs2 = 5'd0;
  logic        mem_busy = 1'b0;
  logic        pc_en, if_id_en, ex_mem_en, if_id_clr, id_ex_clr;
  logic [1:0]  pc_sel;
  logic        mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  pipeline_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_req   (flush_req),
    .jmp_sel     (jmp_sel),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .mem_busy    (mem_busy),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .ex_mem_en   (ex_mem_en),
    .if_id_clr   (if_id_clr),
    .id_ex_clr   (id_ex_clr),
    .pc_sel      (pc_sel),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  // {pc_en, if_id_en, ex_mem_en, if_id_clr, id_ex_clr, pc_sel}
  localparam logic [6:0] V_RUN   = 7'b111_00_00;
  localparam logic [6:0] V_STALL = 7'b001_01_00;
  localparam logic [6:0] V_FRZ   = 7'b000_00_00;
  localparam logic [6:0] V_FL01  = 7'b111_11_01;
  localparam logic [6:0] V_FL10  = 7'b111_11_10;

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        exp_to = 1'b0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_flush = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".ctl"}, {57'd0, pc_en, if_id_en, ex_mem_en, if_id_clr, id_ex_clr, pc_sel},
            {57'd0, e.ctl});
      check({e.name, ".cnt"}, {mem_timeout, stall_cnt[30:0], flush_cnt},
            {e.to, e.sc[30:0], e.fc});
    end
  end

  task automatic push_exp(input string name, input logic [6:0] ctl);
    exp_t e;
    e.name = name;
    e.ctl  = ctl;
    e.to   = exp_to;
`ifdef PERF_CNT_EN
    e.sc = m_stall;
    e.fc = m_flush;
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    sb.push_back(e);
    if (!ctl[6]) m_stall++;
    if (ctl[3])  m_flush++;
  endtask

  task automatic cyc(input string name, input logic fl, input logic [1:0] js,
                     input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic busy, input logic [6:0] ctl);
    @(posedge clk);
    #1;
    flush_req = fl; jmp_sel = js; ex_mem_read = mr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; mem_busy = busy;
    push_exp(name, ctl);
  endtask

  // Reset is pulsed between edges, so the monitor sees its asynchronous effect.
  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    flush_req = 0; jmp_sel = 0; ex_mem_read = 0; ex_rd = 0;
    id_rs1 = 0; id_rs2 = 0; mem_busy = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m_stall = 0; m_flush = 0; exp_to = 1'b0;
    push_exp(name, V_RUN);
  endtask

  initial begin
    do_reset("reset");
    cyc("idle_nomatch",  0, 2'b00, 1, 5'd5, 5'd3, 5'd4, 0, V_RUN);
    cyc("match_noload",  0, 2'b00, 0, 5'd5, 5'd5, 5'd0, 0, V_RUN);
    cyc("lu_rs2",        0, 2'b00, 1, 5'd5, 5'd1, 5'd5, 0, V_STALL);
    cyc("after_lu",      0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);
    cyc("lu_rs1",        0, 2'b00, 1, 5'd7, 5'd7, 5'd2, 0, V_STALL);
    cyc("rd_zero",       0, 2'b00, 1, 5'd0, 5'd0, 5'd9, 0, V_RUN);

    do_reset("reset2");
    cyc("flush_over_lu", 1, 2'b01, 1, 5'd5, 5'd1, 5'd5, 0, V_FL01);
    cyc("after_flush",   0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);
    cyc("flush_jump",    1, 2'b10, 0, 5'd0, 5'd0, 5'd0, 0, V_FL10);

    cyc("mw_c1",         0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    cyc("mw_c2_flush",   1, 2'b10, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    cyc("mw_c3_noovr",   1, 2'b01, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    cyc("mw_exit",       0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_FRZ);
    cyc("redirect",      0, 2'b00, 1, 5'd3, 5'd3, 5'd0, 0, V_FL10);
    cyc("post_redir",    0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);

    cyc("busy_over_fl",  1, 2'b01, 1, 5'd4, 5'd4, 5'd0, 1, V_FRZ);
    cyc("mw_exit2",      0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_FRZ);
    cyc("redir_busy",    0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    cyc("mw_exit3",      0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_FRZ);
    cyc("redir_kept",    0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_FL01);
    cyc("run_again",     0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);

    cyc("busy_nopend",   0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    cyc("exit_nopend",   0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_FRZ);
    cyc("no_redirect",   0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);

    // Cycle 0 is the RUN cycle; MEM_WAIT cycle k is loop index k.
    for (int i = 0; i < 300; i++) begin
      exp_to = (i >= 256);
      cyc("wd_hold", 0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    end
    cyc("wd_exit",       0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_FRZ);
    cyc("wd_sticky",     0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);
    cyc("wd_sticky2",    0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);

    cyc("rst_mw_fl",     1, 2'b01, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    cyc("rst_mw_hold",   0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 1, V_FRZ);
    do_reset("rst_mid_mw");
    cyc("rst_no_redir",  0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);
    cyc("rst_lu",        0, 2'b00, 1, 5'd6, 5'd0, 5'd6, 0, V_STALL);
    cyc("rst_final",     0, 2'b00, 0, 5'd0, 5'd0, 5'd0, 0, V_RUN);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 flush_req  in  1  taken jump/branch resolved in EX (jump unit flush).
REQ-004 jmp_sel  in  2  PC mux select from jump unit (01 branch target, 10 jump/next path, 00 PC+4).
REQ-005 ex_mem_read  in  1  instruction in EX is a load.
REQ-006 ex_rd  in  5  destination register of EX instruction.
REQ-007 id_rs1, id_rs2  in  5 each  source registers of ID instruction.
REQ-008 mem_busy  in  1  data memory not ready; whole pipeline must freeze.
REQ-009 pc_en, if_id_en, ex_mem_en  out  1 each  register write enables.
REQ-010 if_id_clr, id_ex_clr  out  1 each  synchronous bubble insert for the named pipeline register.
REQ-011 pc_sel  out  2  final PC mux select.
REQ-012 mem_timeout  out  1  sticky watchdog flag.
REQ-013 stall_cnt, flush_cnt  out  32 each  performance counters (PERF_CNT_EN only).

Function
REQ-014 FSM states: RUN, MEM_WAIT, REDIRECT; pending-flush register pend (1 bit) and pend_sel (2 bits).
REQ-015 RUN, idle: all enables 1, clears 0, pc_sel=00.
REQ-016 RUN, load-use hazard (ex_mem_read, ex_rd!=0, ex_rd equals id_rs1 or id_rs2): pc_en=0, if_id_en=0, id_ex_clr=1, ex_mem_en=1; stays RUN.
REQ-017 RUN, flush_req=1: if_id_clr=1, id_ex_clr=1, pc_sel=jmp_sel, enables 1; flush overrides load-use in the same cycle.
REQ-018 RUN, mem_busy=1: all enables 0, clears 0, pc_sel=00; next state MEM_WAIT; flush_req in that cycle sets pend=1 and pend_sel=jmp_sel. mem_busy overrides flush and load-use.
REQ-019 MEM_WAIT: all enables 0, clears 0; first flush_req seen sets pend/pend_sel, later ones do not overwrite.
REQ-020 MEM_WAIT exit on mem_busy=0: to REDIRECT if pend=1, else RUN; the exit cycle itself keeps outputs frozen.
REQ-021 REDIRECT: enables 1, if_id_clr=1, id_ex_clr=1, pc_sel=pend_sel; clears pend; next state RUN; mem_busy=1 here sends the FSM back to MEM_WAIT with pend retained.
REQ-022 Watchdog: 8-bit counter increments each MEM_WAIT cycle, clears on leaving; reaching 255 sets mem_timeout, held until reset; counter saturates at 255.
REQ-023 All outputs are combinational from state plus inputs; all state updates on the rising clk edge.

Reset
REQ-024 rst_n=0 forces state RUN, pend=0, pend_sel=00, watchdog=0, mem_timeout=0, counters=0, immediately and independent of clk.
REQ-025 Reset during MEM_WAIT or REDIRECT discards any pending flush.

Configuration
REQ-026 PERF_CNT_EN defined: stall_cnt increments in each cycle where pc_en=0; flush_cnt increments once per applied flush (RUN flush or REDIRECT); both wrap modulo 2^32.
REQ-027 PERF_CNT_EN undefined: counters are not built and stall_cnt/flush_cnt are driven to constant 0.

Structure
REQ-028 State encoding and the PC-select codes (00 PC+4, 01 branch target, 10 jump/next path) belong in a shared package used by the jump unit and this block.
REQ-029 One sub-module, hazard_detect, implements the combinational load-use compare; the FSM, watchdog and counters stay in pipeline_ctrl.

Verification
REQ-030 ex_mem_read=1, ex_rd=5, id_rs2=5, no flush -> pc_en=0, if_id_en=0, id_ex_clr=1 for one cycle; stall_cnt=1.
REQ-031 Same hazard with flush_req=1, jmp_sel=01 -> pc_sel=01, both clears 1, pc_en=1; flush_cnt=1, stall_cnt=0.
REQ-032 mem_busy high 3 cycles, flush_req with jmp_sel=10 in the 2nd cycle -> 4 frozen cycles, then 1 REDIRECT cycle with pc_sel=10 and both clears 1, then RUN.
REQ-033 mem_busy held 300 cycles -> mem_timeout rises after the 255th MEM_WAIT cycle and stays 1 after mem_busy drops.
REQ-034 rst_n pulsed low mid-MEM_WAIT with pend=1 -> state RUN, no REDIRECT afterwards, all counters 0.
REQ-035 ex_rd=0 with matching id_rs1=0 and ex_mem_read=1 -> no stall.
